bitcnt_issue: RTL and testbench

- Sequential issue/retire stage wrapped around the combinational bit-count unit `bitcnt` (din_data/din_func/dout_data, funcs CLZ/CTZ/PCNT in 64- and 32-bit forms).
- Buffers incoming ops in a small FIFO and normalises 32-bit operands.
- Drives `bitcnt` from the FIFO head and registers each result into a valid/ready output slot, carrying a tag.
- Sits between the core's decode/dispatch and writeback.

---
 rtl/bitcnt_pkg.sv | 25 ++
 rtl/bitcnt_issue_if.sv | 26 ++
 rtl/bitcnt.sv | 48 ++++
 rtl/bitcnt_fifo.sv | 43 ++++
 rtl/bitcnt_issue.sv | 90 +++++++++
 tb/tb_bitcnt_issue.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/bitcnt_pkg.sv
// rtl/bitcnt_pkg.sv - shared op types, func encodings and helpers for the bit-count issue stage
package bitcnt_pkg;

    typedef enum logic [1:0] {
        CLZ  = 2'b00,
        CTZ  = 2'b01,
        PCNT = 2'b10,
        RSVD = 2'b11
    } func_e;

    localparam int W32_BIT  = 0;
    // Widest tag the stored op can carry; the stage uses the low TAGW bits.
    localparam int TAG_MAXW = 16;

    typedef struct packed {
        logic [63:0]         data;
        logic [2:0]          func;
        logic [TAG_MAXW-1:0] tag;
    } op_t;

    function automatic logic is_rsvd(input logic [2:0] func);
        return func_e'(func[2:1]) == RSVD;
    endfunction

endpackage

// File: rtl/bitcnt_issue_if.sv
// rtl/bitcnt_issue_if.sv - issue (in_*) and retire (out_*) handshake bundle for bitcnt_issue
interface bitcnt_issue_if #(
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     in_data;
    logic [2:0]      in_func;
    logic [TAGW-1:0] in_tag;

    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [TAGW-1:0] out_tag;
    logic            out_err;

    modport master (
        output in_valid, in_data, in_func, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_func, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/bitcnt.sv
// rtl/bitcnt.sv - combinational CLZ/CTZ/PCNT unit, 64- and 32-bit forms
module bitcnt
    import bitcnt_pkg::*;
(
    input  logic        mutsel,
    input  logic [63:0] din_data,
    input  logic [2:0]  din_func,
    output logic [63:0] dout_data
);
    logic [63:0] clz_src;
    logic [63:0] ctz_src;
    logic [63:0] pcnt_src;
    logic [6:0]  clz;
    logic [6:0]  ctz;
    logic [6:0]  pcnt;
    logic        unused_mutsel;

    assign unused_mutsel = mutsel;

    always_comb begin
        // 32-bit forms reuse the 64-bit scans by padding with ones on the far side
        if (din_func[W32_BIT]) begin
            clz_src  = {din_data[31:0], 32'hFFFF_FFFF};
            ctz_src  = {32'hFFFF_FFFF, din_data[31:0]};
            pcnt_src = {32'h0, din_data[31:0]};
        end else begin
            clz_src  = din_data;
            ctz_src  = din_data;
            pcnt_src = din_data;
        end
        clz  = 7'd64;
        ctz  = 7'd64;
        pcnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (clz_src[i]) clz = 7'(63 - i);
            pcnt = pcnt + 7'(pcnt_src[i]);
        end
        for (int i = 63; i >= 0; i--) begin
            if (ctz_src[i]) ctz = 7'(i);
        end
        case (func_e'(din_func[2:1]))
            CLZ:     dout_data = {57'd0, clz};
            CTZ:     dout_data = {57'd0, ctz};
            PCNT:    dout_data = {57'd0, pcnt};
            default: dout_data = 64'd0;
        endcase
    end
endmodule

// File: rtl/bitcnt_fifo.sv
// rtl/bitcnt_fifo.sv - DEPTH-entry synchronous FIFO with occupancy count
module bitcnt_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0],
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

    assert property (@(posedge clock) disable iff (!resetn) count <= CW'(DEPTH));
    assert property (@(posedge clock) disable iff (!resetn) !(pop && count == '0));
endmodule

// File: rtl/bitcnt_issue.sv
// rtl/bitcnt_issue.sv - FIFO-buffered issue/retire wrapper around bitcnt; BITCNT_ILLEGAL_TRAP_EN traps func 11z
module bitcnt_issue
    import bitcnt_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          mutsel,
    bitcnt_issue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    op_t             push_op;
    op_t             head;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            ready;
    logic            trap;
    logic [63:0]     bc_data;
    logic            out_valid_q;
    logic [63:0]     out_data_q;
    logic [TAGW-1:0] out_tag_q;
    logic            out_err_q;
    logic            unused_head_tag;

    // The pop term lets a full FIFO accept while the result slot drains.
    assign pop   = (count != '0) && (!out_valid_q || bus.out_ready);
    assign ready = (count != CW'(DEPTH)) || pop;
    assign push  = bus.in_valid && ready;

    always_comb begin
        push_op.data = bus.in_data;
        if (bus.in_func[W32_BIT]) push_op.data[63:32] = 32'h0;
        push_op.func = bus.in_func;
        push_op.tag  = TAG_MAXW'(bus.in_tag);
    end

    bitcnt_fifo #(
        .DEPTH (DEPTH),
        .T     (op_t)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .din    (push_op),
        .pop    (pop),
        .dout   (head),
        .count  (count)
    );

    bitcnt u_bitcnt (
        .mutsel    (mutsel),
        .din_data  (head.data),
        .din_func  (head.func),
        .dout_data (bc_data)
    );

`ifdef BITCNT_ILLEGAL_TRAP_EN
    assign trap = is_rsvd(head.func);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= trap ? 64'd0 : bc_data;
            out_tag_q   <= head.tag[TAGW-1:0];
            out_err_q   <= trap;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign unused_head_tag = ^head.tag;

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_bitcnt_issue.sv
// tb/tb_bitcnt_issue.sv - directed self-checking bench for bitcnt_issue
module tb_bitcnt_issue;
    logic clock;
    logic resetn;
    logic mutsel;
    int   n_checks;
    int   n_errors;
    int   seen;

    logic [63:0] rd;
    logic [3:0]  rt;
    logic        re;
    logic [63:0] rd2;
    logic [3:0]  rt2;
    logic        re2;

    bitcnt_issue_if #(.TAGW(4)) bus ();

    bitcnt_issue #(
        .DEPTH (2),
        .TAGW  (4)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .mutsel (mutsel),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_one(input logic [63:0] d, input logic [2:0] f, input logic [3:0] t,
                           output logic [63:0] r_data, output logic [3:0] r_tag, output logic r_err);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_func  = f;
        bus.in_tag   = t;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.out_valid) check("run_one_timeout", 64'(bus.out_valid), 64'd1);
        r_data = bus.out_data;
        r_tag  = bus.out_tag;
        r_err  = bus.out_err;
        tick();
    endtask

    // Three PCNT64 ops (tags 0,1,2 -> counts 1,2,3) with the consumer stalled.
    task automatic fill3();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_func  = 3'b100;
            bus.in_tag   = 4'(i);
            bus.in_data  = (64'd1 << (i + 1)) - 64'd1;
            check("fill_in_ready", 64'(bus.in_ready), 64'd1);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        resetn        = 1'b0;
        mutsel        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_func   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_out_err", 64'(bus.out_err), 64'd0);
        resetn = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Latency: accept at edge 1, result visible after edge 2
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hFFFF_0000_FFFF_0000;
        bus.in_func  = 3'b100;
        bus.in_tag   = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        check("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_edge2_valid", 64'(bus.out_valid), 64'd1);
        check("lat_pcnt64", bus.out_data, 64'd32);
        check("lat_tag", 64'(bus.out_tag), 64'd3);
        tick();
        check("drain_valid", 64'(bus.out_valid), 64'd0);
        check("drain_data_hold", bus.out_data, 64'd32);

        // 32-bit normalisation and boundary counts
        run_one(64'hDEAD_BEEF_0000_0001, 3'b001, 4'd1, rd, rt, re);
        run_one(64'h0000_0000_0000_0001, 3'b001, 4'd2, rd2, rt2, re2);
        check("clz32_upper_ignored", rd, 64'd31);
        check("clz32_upper_zero", rd2, 64'd31);
        check("clz32_tag", 64'(rt2), 64'd2);
        run_one(64'h0000_0000_0000_0001, 3'b000, 4'd4, rd, rt, re);
        check("clz64_one", rd, 64'd63);
        run_one(64'hFFFF_FFFF_FFFF_FFFF, 3'b101, 4'd5, rd, rt, re);
        check("pcnt32_all_ones", rd, 64'd32);
        run_one(64'hFFFF_FFFF_0000_0000, 3'b011, 4'd6, rd, rt, re);
        check("ctz32_low_zero", rd, 64'd32);
        run_one(64'h0000_0000_0000_0000, 3'b000, 4'd7, rd, rt, re);
        check("clz64_zero", rd, 64'd64);

        // Backpressure with DEPTH=2: slot holds tag 0, FIFO holds tags 1,2
        fill3();
        check("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_out_tag0", 64'(bus.out_tag), 64'd0);
        tick();
        tick();
        check("bp_data_stable", bus.out_data, 64'd1);
        check("bp_tag_stable", 64'(bus.out_tag), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_pop_term", 64'(bus.in_ready), 64'd1);
        tick();
        check("bp_out_tag1", 64'(bus.out_tag), 64'd1);
        check("bp_out_data1", bus.out_data, 64'd2);
        tick();
        check("bp_out_tag2", 64'(bus.out_tag), 64'd2);
        check("bp_out_data2", bus.out_data, 64'd3);
        check("bp_valid2", 64'(bus.out_valid), 64'd1);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Back-to-back CTZ64: 0x8, 0x0, 0x1 -> 3, 64, 0 on consecutive cycles
        bus.in_valid = 1'b1;
        bus.in_func  = 3'b010;
        bus.in_tag   = 4'd8;
        bus.in_data  = 64'h8;
        tick();
        bus.in_data  = 64'h0;
        bus.in_tag   = 4'd9;
        check("b2b_in_ready0", 64'(bus.in_ready), 64'd1);
        tick();
        check("b2b_ctz_8", bus.out_data, 64'd3);
        check("b2b_tag_8", 64'(bus.out_tag), 64'd8);
        check("b2b_in_ready1", 64'(bus.in_ready), 64'd1);
        bus.in_data  = 64'h1;
        bus.in_tag   = 4'd10;
        tick();
        bus.in_valid = 1'b0;
        check("b2b_ctz_0", bus.out_data, 64'd64);
        check("b2b_in_ready2", 64'(bus.in_ready), 64'd1);
        tick();
        check("b2b_ctz_1", bus.out_data, 64'd0);
        check("b2b_tag_1", 64'(bus.out_tag), 64'd10);
        tick();

        // Asynchronous reset with two ops queued and a result pending
        fill3();
        check("mid_valid_before", 64'(bus.out_valid), 64'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_data", bus.out_data, 64'd0);
        #2;
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("mid_no_stale", 64'(seen), 64'd0);
        run_one(64'hF, 3'b100, 4'd9, rd, rt, re);
        check("post_rst_data", rd, 64'd4);
        check("post_rst_tag", 64'(rt), 64'd9);

`ifdef BITCNT_ILLEGAL_TRAP_EN
        run_one(64'hFF, 3'b110, 4'd5, rd, rt, re);
        check("trap_err", 64'(re), 64'd1);
        check("trap_data", rd, 64'd0);
        check("trap_tag", 64'(rt), 64'd5);
        run_one(64'hFF, 3'b100, 4'd6, rd, rt, re);
        check("trap_next_err", 64'(re), 64'd0);
        check("trap_next_data", rd, 64'd8);
`else
        run_one(64'hFF, 3'b110, 4'd5, rd, rt, re);
        check("rsvd_err_tied", 64'(re), 64'd0);
        check("rsvd_tag", 64'(rt), 64'd5);
        run_one(64'hFF, 3'b100, 4'd6, rd, rt, re);
        check("rsvd_next_data", rd, 64'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
